norm_result_collector: RTL and testbench
========================================

// Module: norm_result_collector
// PURPOSE
//   Downstream of the normalisation top (mul / div / sqrt / adder-tree lanes A..D).
//   The four lanes finish with independent o_valid_final_* pulses and may be skewed
//   by differing per-lane pipeline depths. Each lane result is buffered in a per-lane FIFO.
//   Results are re-aligned into one packed 4-lane beat and handed to the consumer on a
//   valid/ready handshake, stamped with a sequence number.
// PARAMETERS
//   DATAWIDTH  16  lane input width is DATAWIDTH+1 (Q(DATAWIDTH-FRAC_BITS+1).FRAC_BITS, unsigned)
//   FRAC_BITS  8   fractional bits; informational only, no arithmetic performed
//   DEPTH      8   entries per lane FIFO; power of two, >=2
//   SEQW       8   width of the output sequence tag
// PORTS
//   clk          in   1              rising-edge clock
//   rst          in   1              synchronous, active-high reset
//   i_valid_A..D in   1 each         lane result strobe (from o_valid_final_*)
//   i_data_A..D  in   DATAWIDTH+1    lane result (from output_final_*)
//   o_valid      out  1              packed beat available
//   i_ready      in   1              consumer accepts beat when o_valid&&i_ready
//   o_data_A..D  out  DATAWIDTH+1    aligned lane results (FIFO heads)
//   o_seq        out  SEQW           index of current beat, from 0
//   o_overflow   out  4              sticky per-lane drop flag {A,B,C,D}
//   o_level_max  out  $clog2(DEPTH)+1  occupancy of fullest lane FIFO
// BEHAVIOUR
//   - Reset (rst=1 at a posedge): all FIFO pointers/counts->0; o_valid=0; o_data_*=0;
//     o_seq=0; o_overflow=0; o_level_max=0. Reset mid-stream discards all buffered data;
//     lane strobes in the reset cycle are ignored.
//   - Push: lane X with i_valid_X=1 at a posedge writes i_data_X if count_X<DEPTH,
//     or count_X==DEPTH and a pop occurs in the same cycle (full + pop + push = count unchanged).
//   - Drop: i_valid_X=1 while count_X==DEPTH and no pop -> data discarded, o_overflow[X]
//     set and held until rst. The FIFO contents are untouched.
//   - o_valid = all four counts nonzero (combinational from registered counts).
//   - o_data_X = head of FIFO X when o_valid=1, else 0. Stable while o_valid&&!i_ready.
//   - Latency: the beat becomes valid the cycle after the push of its last-arriving lane
//     (1 clk). Lanes arriving in the same cycle -> o_valid next cycle.
//   - Pop: o_valid&&i_ready at a posedge pops all four FIFOs together and increments o_seq,
//     which wraps 2^SEQW-1 -> 0.
//   - No pop when o_valid=0, regardless of i_ready. Lanes never pop individually; alignment
//     is by order of arrival per lane.
//   - Empty lane with simultaneous push: not visible until next cycle (no fall-through bypass).
//   - Throughput: 1 beat/clk sustained when i_ready=1 and lanes keep up.
//   - o_level_max is registered max(count_A..D), updated every cycle.
//   - Counts are $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap naturally.
// TESTING
//   1 all lanes valid same cycle with A..D=0x00100,0x00200,0x00300,0x00400, i_ready=1
//     -> next cycle o_valid=1, o_data matches, o_seq=0; following beat o_seq=1.
//   2 skew: A@t0, B@t2, C@t5, D@t9 with 0x00180 each -> o_valid first at t10.
//     o_valid=0 at t1..t9, o_data_*=0 while invalid.
//   3 backpressure: i_ready=0, push 3 aligned beats -> beat0 held stable, o_level_max=3.
//     Raise i_ready -> beats 0,1,2 out in 3 consecutive cycles, in order, o_seq 0,1,2.
//   4 overflow: DEPTH=8, i_ready=0, push 9 on A (others 8) -> o_overflow=4'b1000.
//     Drain yields 8 beats with A values 1..8; flag stays set.
//   5 full + push + pop same cycle on all lanes -> counts stay 8, no overflow, order kept.
//   6 rst asserted with 5 beats buffered -> next cycle o_valid=0, o_seq=0, o_overflow=0.
//     A fresh beat afterwards emerges with o_seq=0.

Source files
------------

// File: rtl/norm_result_collector.sv
// Re-aligns four independently-timed lane results into one packed beat via per-lane FIFOs,
// handed downstream on a valid/ready handshake with a wrapping sequence tag.
module norm_result_collector #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SEQW      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid_A,
  input  logic                       i_valid_B,
  input  logic                       i_valid_C,
  input  logic                       i_valid_D,
  input  logic [DATAWIDTH:0]         i_data_A,
  input  logic [DATAWIDTH:0]         i_data_B,
  input  logic [DATAWIDTH:0]         i_data_C,
  input  logic [DATAWIDTH:0]         i_data_D,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATAWIDTH:0]         o_data_A,
  output logic [DATAWIDTH:0]         o_data_B,
  output logic [DATAWIDTH:0]         o_data_C,
  output logic [DATAWIDTH:0]         o_data_D,
  output logic [SEQW-1:0]            o_seq,
  output logic [3:0]                 o_overflow,
  output logic [$clog2(DEPTH):0]     o_level_max
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  if (FRAC_BITS > DATAWIDTH + 1) begin : g_bad_frac
    $error("FRAC_BITS exceeds lane width");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end

  // Lane index 0..3 corresponds to A..D throughout.
  logic [3:0]           push_v;
  logic [DATAWIDTH:0]   push_d [4];
  logic [DATAWIDTH:0]   mem_q  [4][DEPTH];
  logic [PW-1:0]        wptr_q [4];
  logic [PW-1:0]        rptr_q [4];
  logic [CW-1:0]        cnt_q  [4];
  logic [CW-1:0]        cnt_d  [4];
  logic [3:0]           push_ok;
  logic [3:0]           drop;
  logic [3:0]           ovf_q;
  logic [CW-1:0]        lvl_q;
  logic [CW-1:0]        lvl_d;
  logic [SEQW-1:0]      seq_q;
  logic                 beat_valid;
  logic                 pop;

  assign push_v    = {i_valid_D, i_valid_C, i_valid_B, i_valid_A};
  assign push_d[0] = i_data_A;
  assign push_d[1] = i_data_B;
  assign push_d[2] = i_data_C;
  assign push_d[3] = i_data_D;

  always_comb begin
    beat_valid = 1'b1;
    for (int l = 0; l < 4; l++) begin
      beat_valid = beat_valid & (cnt_q[l] != '0);
    end
    pop   = beat_valid & i_ready;
    lvl_d = '0;
    for (int l = 0; l < 4; l++) begin
      // A full lane can still accept when the beat pops in the same cycle.
      push_ok[l] = push_v[l] & ((cnt_q[l] != Full) | pop);
      drop[l]    = push_v[l] & (cnt_q[l] == Full) & ~pop;
      cnt_d[l]   = cnt_q[l] + CW'(push_ok[l]) - CW'(pop);
      if (cnt_d[l] > lvl_d) begin
        lvl_d = cnt_d[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < 4; l++) begin
        wptr_q[l] <= '0;
        rptr_q[l] <= '0;
        cnt_q[l]  <= '0;
      end
      ovf_q <= '0;
      lvl_q <= '0;
      seq_q <= '0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        cnt_q[l] <= cnt_d[l];
        if (push_ok[l]) begin
          wptr_q[l] <= wptr_q[l] + PW'(1);
        end
        if (pop) begin
          rptr_q[l] <= rptr_q[l] + PW'(1);
        end
      end
      ovf_q <= ovf_q | drop;
      lvl_q <= lvl_d;
      if (pop) begin
        seq_q <= seq_q + SEQW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (!rst && push_ok[l]) begin
        mem_q[l][wptr_q[l]] <= push_d[l];
      end
    end
  end

  assign o_valid     = beat_valid;
  assign o_data_A    = beat_valid ? mem_q[0][rptr_q[0]] : '0;
  assign o_data_B    = beat_valid ? mem_q[1][rptr_q[1]] : '0;
  assign o_data_C    = beat_valid ? mem_q[2][rptr_q[2]] : '0;
  assign o_data_D    = beat_valid ? mem_q[3][rptr_q[3]] : '0;
  assign o_seq       = seq_q;
  assign o_overflow  = {ovf_q[0], ovf_q[1], ovf_q[2], ovf_q[3]};
  assign o_level_max = lvl_q;

endmodule

// File: tb/tb_norm_result_collector.sv
// Scoreboard bench: queue-based lane model forms expected beats; a monitor pops them on handshakes.
module tb_norm_result_collector;

  localparam int DW    = 16;
  localparam int LW    = DW + 1;
  localparam int DEPTH = 8;
  localparam int SEQW  = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [SEQW-1:0]     seq;
    logic [3:0][LW-1:0]  d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [3:0]          vin;
  logic [3:0][LW-1:0]  din;
  logic                ready;
  logic                o_valid;
  logic [LW-1:0]       od_a, od_b, od_c, od_d;
  logic [3:0][LW-1:0]  dout;
  logic [SEQW-1:0]     o_seq;
  logic [3:0]          o_overflow;
  logic [CW-1:0]       o_level_max;

  assign dout = {od_d, od_c, od_b, od_a};

  norm_result_collector #(
    .DATAWIDTH(DW), .FRAC_BITS(8), .DEPTH(DEPTH), .SEQW(SEQW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid_A(vin[0]), .i_valid_B(vin[1]), .i_valid_C(vin[2]), .i_valid_D(vin[3]),
    .i_data_A(din[0]), .i_data_B(din[1]), .i_data_C(din[2]), .i_data_D(din[3]),
    .o_valid(o_valid), .i_ready(ready),
    .o_data_A(od_a), .o_data_B(od_b), .o_data_C(od_c), .o_data_D(od_d),
    .o_seq(o_seq), .o_overflow(o_overflow), .o_level_max(o_level_max)
  );

  // Reference model: per-lane arrival queues; a beat forms once every lane holds an entry.
  logic [LW-1:0] lq [4][$];
  beat_t         sb [$];
  int            nbeats;
  logic [SEQW-1:0] form_seq;
  logic [3:0]    exp_ovf;
  int            exp_lvl;
  int            checks = 0;
  int            failures = 0;
  bit            mon_en = 1'b0;
  bit            prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] vv, input logic [3:0][LW-1:0] dd, input logic rr,
                       input logic rs);
    bit    pop;
    beat_t b;
    @(negedge clk);
    vin = vv; din = dd; ready = rr; rst = rs;
    if (rs) begin
      for (int l = 0; l < 4; l++) lq[l].delete();
      sb.delete();
      nbeats = 0; form_seq = '0; exp_ovf = '0; exp_lvl = 0;
    end else begin
      pop = (nbeats > 0) && rr;
      for (int l = 0; l < 4; l++) begin
        if (vv[l]) begin
          if (lq[l].size() + nbeats < DEPTH || pop) lq[l].push_back(dd[l]);
          else exp_ovf[l] = 1'b1;
        end
      end
      if (pop) nbeats--;
      while (lq[0].size() > 0 && lq[1].size() > 0 && lq[2].size() > 0 && lq[3].size() > 0) begin
        b.seq = form_seq;
        for (int l = 0; l < 4; l++) b.d[l] = lq[l].pop_front();
        sb.push_back(b);
        form_seq++;
        nbeats++;
      end
      exp_lvl = 0;
      for (int l = 0; l < 4; l++) begin
        if (lq[l].size() + nbeats > exp_lvl) exp_lvl = lq[l].size() + nbeats;
      end
    end
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) drive(4'b0000, '0, rr, 1'b0);
  endtask

  // Monitor: retire the head beat on each observed handshake, then check the presented beat.
  initial begin
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (!rst && prev_valid && ready && sb.size() > 0) void'(sb.pop_front());
      chk("o_valid", 64'(o_valid), 64'(sb.size() > 0));
      if (sb.size() > 0) begin
        for (int l = 0; l < 4; l++) chk("o_data", 64'(dout[l]), 64'(sb[0].d[l]));
        chk("o_seq", 64'(o_seq), 64'(sb[0].seq));
      end else begin
        chk("o_data_idle", 64'(dout), 64'(0));
      end
      chk("o_overflow", 64'(o_overflow), 64'({exp_ovf[0], exp_ovf[1], exp_ovf[2], exp_ovf[3]}));
      chk("o_level_max", 64'(o_level_max), 64'(exp_lvl));
      prev_valid = o_valid;
    end
  end

  initial begin
    logic [3:0][LW-1:0] dd;
    logic [3:0]         vv;
    rst = 1'b1; vin = '0; din = '0; ready = 1'b0;
    drive(4'b0000, '0, 1'b0, 1'b1);
    mon_en = 1'b1;
    drive(4'b1111, '1, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Aligned beats, back to back.
    dd = {17'h00400, 17'h00300, 17'h00200, 17'h00100};
    drive(4'b1111, dd, 1'b1, 1'b0);
    dd = {17'h00440, 17'h00330, 17'h00220, 17'h00110};
    drive(4'b1111, dd, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Skewed lanes: A@0, B@2, C@5, D@9.
    dd = {4{17'h00180}};
    for (int t = 0; t < 10; t++) begin
      vv = {t == 9, t == 5, t == 2, t == 0};
      drive(vv, dd, 1'b1, 1'b0);
    end
    idle(3, 1'b1);

    // Backpressure: three beats held, then released.
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < 4; l++) dd[l] = LW'(16 * i + l + 1);
      drive(4'b1111, dd, 1'b0, 1'b0);
    end
    idle(4, 1'b0);
    idle(5, 1'b1);

    // Overflow on lane A: nine pushes into a depth-8 FIFO.
    for (int i = 0; i < 9; i++) begin
      for (int l = 0; l < 4; l++) dd[l] = LW'(i + 1 + 32 * l);
      drive({i < 8, i < 8, i < 8, 1'b1}, dd, 1'b0, 1'b0);
    end
    idle(12, 1'b1);

    // Full FIFOs with simultaneous push and pop.
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < 4; l++) dd[l] = LW'($urandom);
      drive(4'b1111, dd, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      for (int l = 0; l < 4; l++) dd[l] = LW'($urandom);
      drive(4'b1111, dd, 1'b1, 1'b0);
    end
    idle(2, 1'b0);

    // Reset with buffered beats, then a fresh beat.
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < 4; l++) dd[l] = LW'($urandom);
      drive(4'b1111, dd, 1'b0, 1'b0);
    end
    drive(4'b1111, dd, 1'b0, 1'b1);
    for (int l = 0; l < 4; l++) dd[l] = LW'($urandom);
    drive(4'b1111, dd, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Random traffic with skew, backpressure bursts and occasional reset.
    for (int i = 0; i < 4000; i++) begin
      for (int l = 0; l < 4; l++) begin
        dd[l] = LW'($urandom);
        vv[l] = ($urandom_range(0, 99) < 55);
      end
      drive(vv, dd, (i % 400) < 300 ? ($urandom_range(0, 99) < 70) : 1'b0,
            $urandom_range(0, 499) == 0);
    end

    idle(DEPTH + 4, 1'b1);
    chk("drained", 64'(sb.size()), 64'(0));
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
